// File: rtl/somador_subtrator_serial_pkg.sv
// Shared types for the digit-serial adder/subtractor: FSM state encoding and op codes.
package somador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Counter width for NCHUNK slices; a single-slice build still needs one bit.
    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/somador_subtrator_serial_if.sv
// Operand/result bundle of the serial adder/subtractor. The ovf wire exists only
// when ADDSUB_OVF_EN is defined.
interface somador_subtrator_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sinal;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef ADDSUB_OVF_EN
    logic             ovf;

    modport master (
        output start, sinal, cin, a, b,
        input  busy, done, s, cout, ovf
    );
    modport slave (
        input  start, sinal, cin, a, b,
        output busy, done, s, cout, ovf
    );
`else
    modport master (
        output start, sinal, cin, a, b,
        input  busy, done, s, cout
    );
    modport slave (
        input  start, sinal, cin, a, b,
        output busy, done, s, cout
    );
`endif
endinterface

// File: rtl/somador_subtrator_serial_fatia.sv
// Combinational CHUNK-bit add/sub slice; cin_i is the already-adjusted carry (borrow inverted).
// c_msb_in_o (carry into the slice MSB) is present only with ADDSUB_OVF_EN.
module somador_subtrator_fatia
    import somador_pkg::*;
#(
    parameter int CHUNK = 2
) (
    input  logic             sinal_i,
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             cout_o
`ifdef ADDSUB_OVF_EN
    ,
    output logic             c_msb_in_o
`endif
);

    logic [CHUNK-1:0] b_eff;
    logic [CHUNK:0]   sum;

    always_comb begin
        b_eff  = b_i ^ {CHUNK{sinal_i == OP_SUB}};
        sum    = {1'b0, a_i} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin_i};
        s_o    = sum[CHUNK-1:0];
        cout_o = sum[CHUNK];
    end

`ifdef ADDSUB_OVF_EN
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB can be recovered from it.
    assign c_msb_in_o = a_i[CHUNK-1] ^ b_eff[CHUNK-1] ^ sum[CHUNK-1];
`endif

endmodule

// File: rtl/somador_subtrator_serial.sv
// Digit-serial two's-complement adder/subtractor, CHUNK bits per clock, LSB slice first.
// Define ADDSUB_OVF_EN to add the signed-overflow flag.
//
// state   | meaning
// IDLE    | waiting for start; results held
// RUN     | one slice per cycle, counter selects result position
// DONE    | done pulse; a new start is accepted here without passing IDLE
module somador_subtrator_serial
    import somador_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    somador_subtrator_serial_if.slave  bus
);

    localparam int              NCHUNK = WIDTH / CHUNK;
    localparam int              CNT_W  = cnt_width(NCHUNK);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             sinal_q, sinal_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic [CHUNK-1:0] sl_s;
    logic             sl_cout;
`ifdef ADDSUB_OVF_EN
    logic             ovf_q, ovf_d;
    logic             sl_c_msb_in;
`endif

    somador_subtrator_fatia #(
        .CHUNK (CHUNK)
    ) u_fatia (
        .sinal_i    (sinal_q),
        .a_i        (a_q[CHUNK-1:0]),
        .b_i        (b_q[CHUNK-1:0]),
        .cin_i      (carry_q),
        .s_o        (sl_s),
        .cout_o     (sl_cout)
`ifdef ADDSUB_OVF_EN
        ,
        .c_msb_in_o (sl_c_msb_in)
`endif
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        sinal_d = sinal_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef ADDSUB_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sinal_d = bus.sinal;
                    // Subtraction is a + ~b + 1, so the borrow-in is inverted into a carry.
                    carry_d = bus.cin ^ (bus.sinal == OP_SUB);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        s_d[k*CHUNK +: CHUNK] = sl_s;
                    end
                end
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = sl_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cout_d  = sl_cout;
`ifdef ADDSUB_OVF_EN
                    ovf_d   = sl_c_msb_in ^ sl_cout;
`endif
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sinal_q <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef ADDSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            sinal_q <= sinal_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef ADDSUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
`ifdef ADDSUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_somador_subtrator_serial.sv
// Self-checking bench: WIDTH=8 with CHUNK=2 and CHUNK=8 instances, directed table,
// hand-written handshake/reset sequences and randomized ops against an integer model.
module tb_somador_subtrator_serial;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    somador_subtrator_serial_if #(.WIDTH(8)) bus ();
    somador_subtrator_serial_if #(.WIDTH(8)) bus8 ();

    somador_subtrator_serial #(.WIDTH(8), .CHUNK(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    somador_subtrator_serial #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sinal;
        logic       cin;
        logic [7:0] s;
        logic       cout;
        logic       ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Plain integer arithmetic: a+b+cin or a-b-cin, then wrap and range-check.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  input logic sinal, input logic cin,
                                  output logic [7:0] s, output logic cout, output logic ovf);
        int ur, sr;
        if (sinal) begin
            ur   = int'(a) - int'(b) - int'(cin);
            sr   = int'($signed(a)) - int'($signed(b)) - int'(cin);
            cout = (ur >= 0);
        end else begin
            ur   = int'(a) + int'(b) + int'(cin);
            sr   = int'($signed(a)) + int'($signed(b)) + int'(cin);
            cout = (ur > 255);
        end
        s   = ur[7:0];
        ovf = (sr > 127) || (sr < -128);
    endfunction

    task automatic get_out(input bit sel, output logic [7:0] s, output logic c, output logic o);
        s = sel ? bus8.s : bus.s;
        c = sel ? bus8.cout : bus.cout;
`ifdef ADDSUB_OVF_EN
        o = sel ? bus8.ovf : bus.ovf;
`else
        o = 1'b0;
`endif
    endtask

    // Waits for done (bounded), counting cycles from the previous sample point.
    task automatic wait_done(input bit sel, output int lat, output logic busy1);
        bit seen = 0;
        lat   = 0;
        busy1 = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) busy1 = sel ? bus8.busy : bus.busy;
            if (sel ? bus8.done : bus.done) seen = 1;
        end
    endtask

    task automatic do_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                         input logic sinal, input logic cin, input bit scramble,
                         output logic [7:0] s, output logic c, output logic o,
                         output int lat, output logic busy1);
        @(negedge clk);
        if (sel) begin
            bus8.a = a; bus8.b = b; bus8.sinal = sinal; bus8.cin = cin; bus8.start = 1'b1;
        end else begin
            bus.a = a; bus.b = b; bus.sinal = sinal; bus.cin = cin; bus.start = 1'b1;
        end
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus8.start = 1'b0;
        if (scramble) begin
            bus.a  = 8'($urandom); bus.b  = 8'($urandom); bus.sinal  = 1'($urandom); bus.cin  = 1'($urandom);
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.sinal = 1'($urandom); bus8.cin = 1'($urandom);
        end
        wait_done(sel, lat, busy1);
        get_out(sel, s, c, o);
    endtask

    task automatic check_op(input string tag, input bit sel, input logic [7:0] a, input logic [7:0] b,
                            input logic sinal, input logic cin, input bit scramble,
                            input logic [7:0] es, input logic ec, input logic eo);
        logic [7:0] s;
        logic       c, o, busy1;
        int         lat;
        do_op(sel, a, b, sinal, cin, scramble, s, c, o, lat, busy1);
        chk({tag, " latency"}, 32'(lat), sel ? 32'd1 : 32'd4);
        if (!sel) chk({tag, " busy"}, 32'(busy1), 32'd1);
        chk({tag, " s"}, 32'(s), 32'(es));
        chk({tag, " cout"}, 32'(c), 32'(ec));
`ifdef ADDSUB_OVF_EN
        chk({tag, " ovf"}, 32'(o), 32'(eo));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vt[8];
        logic [7:0] es, s;
        logic       ec, eo, c, o;
        int         lat;
        logic       busy1;

        vt[0] = '{8'h25, 8'h13, 1'b0, 1'b0, 8'h38, 1'b0, 1'b0};
        vt[1] = '{8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0};
        vt[2] = '{8'h01, 8'h02, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
        vt[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        vt[5] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[6] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vt[7] = '{8'h0F, 8'h01, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};

        bus.start  = 1'b0; bus.a  = '0; bus.b  = '0; bus.sinal  = 1'b0; bus.cin  = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.sinal = 1'b0; bus8.cin = 1'b0;
        rst = 1'b1;
        #1;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset s", 32'(bus.s), 32'd0);
        chk("reset cout", 32'(bus.cout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            check_op($sformatf("vec%0d", i), 1'b0, vt[i].a, vt[i].b, vt[i].sinal, vt[i].cin, 1'b1,
                     vt[i].s, vt[i].cout, vt[i].ovf);

        // Result stays put after done while idle.
        repeat (3) @(posedge clk);
        #1;
        chk("hold s", 32'(bus.s), 32'h11);
        chk("hold done", 32'(bus.done), 32'd0);
        chk("hold busy", 32'(bus.busy), 32'd0);

        // Start held through RUN: only re-accepted in DONE with the operands present then.
        @(negedge clk);
        bus.a = 8'h25; bus.b = 8'h13; bus.sinal = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.a = 8'h10; bus.b = 8'h01; bus.sinal = 1'b1;
        wait_done(1'b0, lat, busy1);
        chk("held first latency", 32'(lat), 32'd4);
        chk("held first s", 32'(bus.s), 32'h38);
        wait_done(1'b0, lat, busy1);
        bus.start = 1'b0;
        chk("b2b latency", 32'(lat), 32'd5);
        chk("b2b busy", 32'(busy1), 32'd1);
        chk("b2b s", 32'(bus.s), 32'h0F);
        chk("b2b cout", 32'(bus.cout), 32'd1);
        @(posedge clk); #1;
        chk("b2b back to idle", 32'(bus.busy), 32'd0);

        // Reset in the second RUN cycle, then a clean operation.
        @(negedge clk);
        bus.a = 8'hFF; bus.b = 8'h01; bus.sinal = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst done", 32'(bus.done), 32'd0);
        chk("midrst s", 32'(bus.s), 32'd0);
        chk("midrst cout", 32'(bus.cout), 32'd0);
`ifdef ADDSUB_OVF_EN
        chk("midrst ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        check_op("after rst", 1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

        // Single-slice build.
        check_op("chunk8", 1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic       rs, rc;
            bit         sel;
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            sel = (i % 4 == 3);
            model(ra, rb, rs, rc, es, ec, eo);
            check_op($sformatf("rnd%0d %0h%s%0h c%0d", i, ra, rs ? "-" : "+", rb, rc), sel,
                     ra, rb, rs, rc, 1'b1, es, ec, eo);
        end

        do_op(1'b0, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, s, c, o, lat, busy1);
        model(8'h80, 8'h80, 1'b0, 1'b0, es, ec, eo);
        chk("neg+neg s", 32'(s), 32'(es));
        chk("neg+neg cout", 32'(c), 32'(ec));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
